// File: rtl/hs32_uart_pkg.sv
// hs32_uart_pkg
//   Shared definitions for the dev_uart MMIO peripheral: register word
//   indices, STATUS/CTRL bit positions, the serial FSM state encoding and
//   the packed CTRL register layout.
package hs32_uart_pkg;

  // Register word indices (mmio_addr[3:2])
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  // STATUS bit positions
  localparam int ST_RX_NEMPTY    = 0;
  localparam int ST_TX_FULL      = 1;
  localparam int ST_TX_EMPTY     = 2;
  localparam int ST_TX_BUSY      = 3;
  localparam int ST_RX_OVERRUN   = 4;
  localparam int ST_FRAME_ERR    = 5;
  localparam int ST_TX_OVF       = 6;
  localparam int ST_RX_COUNT_LSB = 8;
  localparam int ST_TX_COUNT_LSB = 16;
  localparam int ST_COUNT_BITS   = 5;

  // Serial FSM states, shared by the TX and RX engines
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Smallest divisor the RX half-bit sampling point can work with
  localparam int MIN_DIV = 3;

  // CTRL register, tx_en in bit 0
  typedef struct packed {
    logic irq_txe_en;
    logic irq_rx_en;
    logic rx_en;
    logic tx_en;
  } ctrl_t;

endpackage

// File: rtl/dev_uart_fifo.sv
// dev_uart_fifo
//   Synchronous FIFO with same-cycle push and pop. A push into a full FIFO
//   is accepted when a pop happens in the same cycle.
//   clk, reset  : clock, asynchronous active-high reset
//   push, wdata : write request and data (ignored when full without pop)
//   pop, rdata  : read request (ignored when empty); rdata shows the head
//   full, empty : occupancy flags
//   count       : number of stored entries, 0..DEPTH
module dev_uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples its inputs from before the edge, regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; only pointers and count define
  // which entries are valid, so clearing data would only cost logic.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/dev_uart.sv
// dev_uart
//   Memory-mapped 8N1 UART with TX/RX FIFOs and a level interrupt.
//   clk, reset : system clock, asynchronous active-high reset
//   stb/ack    : bus strobe (held until ack) and one-cycle acknowledge
//   we, addr   : write enable, register word index
//   dtw, dtr   : write data, read data (valid while ack = 1)
//   rx_in      : raw asynchronous RX pad input
//   tx_out     : TX line, tx_oe : TX pad drive enable
//   intrq      : level interrupt request
module dev_uart
  import hs32_uart_pkg::*;
#(
  parameter int                  FIFO_DEPTH = 4,
  parameter int                  DIV_BITS   = 16,
  parameter logic [DIV_BITS-1:0] DIV_RESET  = 16'd867
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stb,
  output logic        ack,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] dtw,
  output logic [31:0] dtr,
  input  logic        rx_in,
  output logic        tx_out,
  output logic        tx_oe,
  output logic        intrq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // ---------------------------------------------------------------- bus
  logic access, wr, rd;
  assign access = stb & ~ack;   // one side effect per strobe
  assign wr     = access & we;
  assign rd     = access & ~we;

  ctrl_t               ctrl;
  logic [DIV_BITS-1:0] div_q;
  logic                rx_overrun, frame_err, tx_ovf;
  logic [31:0]         rd_data, status_word;

  // Every dtw bit is consumed somewhere only for some registers.
  logic unused_dtw;
  assign unused_dtw = &{1'b0, dtw};

  // --------------------------------------------------------------- FIFOs
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]    tx_rdata;
  logic [CW-1:0] tx_count;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]    rx_rdata;
  logic [CW-1:0] rx_count;

  assign tx_push = wr & (addr == REG_DATA);
  assign rx_pop  = rd & (addr == REG_DATA);

  dev_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .wdata (dtw[7:0]),
    .pop   (tx_pop),
    .rdata (tx_rdata),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  logic [7:0] rx_sh;

  dev_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .wdata (rx_sh),
    .pop   (rx_pop),
    .rdata (rx_rdata),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // -------------------------------------------------------------- TX FSM
  logic [1:0]          tx_state;
  logic [DIV_BITS-1:0] tx_cnt;
  logic [2:0]          tx_bit;
  logic [7:0]          tx_sh;
  logic                tx_bit_end;
  logic                tx_busy;

  assign tx_busy    = (tx_state != S_IDLE);
  assign tx_bit_end = (tx_cnt >= div_q);
  // tx_en only gates leaving IDLE, so clearing it lets a frame finish.
  assign tx_pop     = (tx_state == S_IDLE) & ctrl.tx_en & ~tx_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_out   <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          tx_out <= 1'b1;
          if (tx_pop) begin
            tx_sh    <= tx_rdata;
            tx_cnt   <= '0;
            tx_out   <= 1'b0;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_bit_end) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_out   <= tx_sh[0];
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + DIV_BITS'(1);
          end
        end
        S_DATA: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_out   <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx_sh  <= tx_sh >> 1;
              tx_out <= tx_sh[1];
              tx_bit <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + DIV_BITS'(1);
          end
        end
        default: begin  // S_STOP
          if (tx_bit_end) begin
            tx_cnt   <= '0;
            tx_state <= S_IDLE;
          end else begin
            tx_cnt <= tx_cnt + DIV_BITS'(1);
          end
        end
      endcase
    end
  end

  // -------------------------------------------------------------- RX FSM
  logic                rx_s1, rx_s2, rx_prev;
  logic [1:0]          rx_state;
  logic [DIV_BITS-1:0] rx_cnt;
  logic [2:0]          rx_bit;
  logic [DIV_BITS:0]   div_p1;
  logic [DIV_BITS-1:0] half_m1;
  logic                rx_tick, rx_stop_tick, rx_frame_bad;

  // Start bit is checked (DIV+1)/2 clocks after the detected falling edge;
  // the counter starts at 0 on the detection cycle, hence the -1.
  assign div_p1  = {1'b0, div_q} + (DIV_BITS+1)'(1);
  assign half_m1 = div_p1[DIV_BITS:1] - DIV_BITS'(1);
  assign rx_tick = (rx_state == S_START) ? (rx_cnt >= half_m1)
                                         : (rx_cnt >= div_q);

  assign rx_stop_tick = ctrl.rx_en & (rx_state == S_STOP) & rx_tick;
  assign rx_push      = rx_stop_tick & rx_s2;
  assign rx_frame_bad = rx_stop_tick & ~rx_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_in;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else if (!ctrl.rx_en) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= '0;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_tick) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? S_IDLE : S_DATA;  // high here = false start
          end else begin
            rx_cnt <= rx_cnt + DIV_BITS'(1);
          end
        end
        S_DATA: begin
          if (rx_tick) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + DIV_BITS'(1);
          end
        end
        default: begin  // S_STOP
          if (rx_tick) begin
            rx_cnt   <= '0;
            rx_state <= S_IDLE;
          end else begin
            rx_cnt <= rx_cnt + DIV_BITS'(1);
          end
        end
      endcase
    end
  end

  // ------------------------------------------------------ read data mux
  // NOTE: each always_comb signal gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    status_word = '0;
    status_word[ST_RX_NEMPTY]  = ~rx_empty;
    status_word[ST_TX_FULL]    = tx_full;
    status_word[ST_TX_EMPTY]   = tx_empty;
    status_word[ST_TX_BUSY]    = tx_busy;
    status_word[ST_RX_OVERRUN] = rx_overrun;
    status_word[ST_FRAME_ERR]  = frame_err;
    status_word[ST_TX_OVF]     = tx_ovf;
    status_word[ST_RX_COUNT_LSB +: ST_COUNT_BITS] = ST_COUNT_BITS'(rx_count);
    status_word[ST_TX_COUNT_LSB +: ST_COUNT_BITS] = ST_COUNT_BITS'(tx_count);
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      REG_DATA:   if (!rx_empty) rd_data[7:0] = rx_rdata;
      REG_STATUS: rd_data = status_word;
      REG_CTRL:   rd_data[3:0] = ctrl;
      default:    rd_data[DIV_BITS-1:0] = div_q;  // REG_DIV
    endcase
  end

  // ----------------------------------------------- registers and flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack        <= 1'b0;
      dtr        <= '0;
      ctrl       <= '0;
      tx_oe      <= 1'b0;
      div_q      <= DIV_RESET;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      tx_ovf     <= 1'b0;
    end else begin
      ack <= access;
      if (access) dtr <= rd ? rd_data : '0;

      if (wr && addr == REG_CTRL) begin
        ctrl  <= ctrl_t'(dtw[3:0]);
        tx_oe <= dtw[0];
      end

      if (wr && addr == REG_DIV)
        div_q <= (dtw[DIV_BITS-1:0] < DIV_BITS'(MIN_DIV)) ? DIV_BITS'(MIN_DIV)
                                                           : dtw[DIV_BITS-1:0];

      // Clears first so a new event in the same cycle wins.
      if (wr && addr == REG_STATUS) begin
        if (dtw[ST_RX_OVERRUN]) rx_overrun <= 1'b0;
        if (dtw[ST_FRAME_ERR])  frame_err  <= 1'b0;
        if (dtw[ST_TX_OVF])     tx_ovf     <= 1'b0;
      end
      // A same-cycle pop makes room, so no flag in that case.
      if (tx_push && tx_full && !tx_pop) tx_ovf     <= 1'b1;
      if (rx_push && rx_full && !rx_pop) rx_overrun <= 1'b1;
      if (rx_frame_bad)                  frame_err  <= 1'b1;
    end
  end

  assign intrq = (ctrl.irq_rx_en & ~rx_empty) |
                 (ctrl.irq_txe_en & tx_empty & ~tx_busy);

endmodule

// File: tb/tb_dev_uart.sv
// tb_dev_uart
//   Scoreboard bench for dev_uart: bus accesses queue their expected read
//   data, a monitor compares on every ack; a TX line monitor checks each
//   transmitted frame cycle by cycle against queued bytes. The reference
//   model keeps FIFO contents as queues and flags as plain bits.
module tb_dev_uart;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, stb, we, rx_in;
  logic [1:0]  addr;
  logic [31:0] dtw;
  logic        ack, tx_out, tx_oe, intrq;
  logic [31:0] dtr;

  always #5 clk = ~clk;

  dev_uart #(.FIFO_DEPTH(DEPTH), .DIV_BITS(16), .DIV_RESET(16'd867)) dut (
    .clk(clk), .reset(reset), .stb(stb), .ack(ack), .we(we), .addr(addr),
    .dtw(dtw), .dtr(dtr), .rx_in(rx_in), .tx_out(tx_out), .tx_oe(tx_oe),
    .intrq(intrq)
  );

  typedef struct {
    bit          is_read;
    logic [31:0] exp;
    string       name;
  } txn_t;

  txn_t       sb_q[$];
  logic [7:0] tx_q[$], rx_q[$], tx_exp[$];
  bit         m_rovr, m_ferr, m_tovf;
  int         m_div;
  logic [3:0] m_ctrl;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[0]     = (rx_q.size() != 0);
    s[1]     = (tx_q.size() == DEPTH);
    s[2]     = (tx_q.size() == 0);
    s[4]     = m_rovr;
    s[5]     = m_ferr;
    s[6]     = m_tovf;
    s[12:8]  = 5'(rx_q.size());
    s[20:16] = 5'(tx_q.size());
    return s;
  endfunction

  // Valid only while the transmitter is idle.
  function automatic logic exp_intrq();
    return (m_ctrl[2] & (rx_q.size() != 0)) | (m_ctrl[3] & (tx_q.size() == 0));
  endfunction

  // ------------------------------------------------------------ bus side
  task automatic bus(input bit w, input logic [1:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input string name);
    txn_t t;
    int   n;
    t.is_read = !w;
    t.exp     = exp;
    t.name    = name;
    sb_q.push_back(t);
    @(negedge clk);
    stb = 1'b1; we = w; addr = a; dtw = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack !== 1'b1 && n < 8);
    stb = 1'b0; we = 1'b0;
    check(ack === 1'b1, {name, "_ack"}, 32'(ack), 1);
    if (ack !== 1'b1) sb_q = {};
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input string name);
    bus(1'b1, a, d, '0, name);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    bus(1'b0, a, '0, exp, name);
  endtask

  task automatic rd_status(input string name);
    rd(2'd1, exp_status(), name);
  endtask

  task automatic rd_pop(input string name);
    logic [31:0] e;
    e = '0;
    if (rx_q.size() != 0) e[7:0] = rx_q.pop_front();
    rd(2'd0, e, name);
  endtask

  task automatic write_data(input logic [7:0] b);
    if (tx_q.size() < DEPTH) begin
      tx_q.push_back(b);
      tx_exp.push_back(b);
    end else begin
      m_tovf = 1'b1;
    end
    wr(2'd0, {24'h0, b}, "wr_data");
  endtask

  task automatic write_ctrl(input logic [31:0] v);
    m_ctrl = v[3:0];
    wr(2'd2, v, "wr_ctrl");
  endtask

  task automatic write_div(input logic [31:0] v);
    m_div = (v[15:0] < 16'd3) ? 3 : int'(v[15:0]);
    wr(2'd3, v, "wr_div");
  endtask

  task automatic clear_flags(input logic [31:0] v);
    if (v[4]) m_rovr = 1'b0;
    if (v[5]) m_ferr = 1'b0;
    if (v[6]) m_tovf = 1'b0;
    wr(2'd1, v, "wr_status");
  endtask

  task automatic wait_tx_drain(input int nbytes);
    repeat (nbytes * (10 * (m_div + 1) + 3) + 20) @(negedge clk);
    tx_q.delete();
    check(tx_exp.size() == 0, "tx_all_sent", 32'(tx_exp.size()), 0);
  endtask

  // 8N1 frame on rx_in at the current bit period
  task automatic send_frame(input logic [7:0] b, input bit stop);
    int p;
    p = m_div + 1;
    @(negedge clk);
    rx_in = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (p) @(negedge clk);
    end
    rx_in = stop;
    repeat (p) @(negedge clk);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    if (m_ctrl[1]) begin
      if (!stop)                    m_ferr = 1'b1;
      else if (rx_q.size() < DEPTH) rx_q.push_back(b);
      else                          m_rovr = 1'b1;
    end
  endtask

  // ------------------------------------------------------- bus monitor
  initial begin
    txn_t t;
    logic prev_ack;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ack === 1'b1) begin
        check(prev_ack !== 1'b1, "ack_one_cycle", 32'(prev_ack), 0);
        if (sb_q.size() == 0) begin
          check(1'b0, "ack_without_request", 1, 0);
        end else begin
          t = sb_q.pop_front();
          if (t.is_read) check(dtr === t.exp, t.name, dtr, t.exp);
        end
      end
      prev_ack = ack;
    end
  end

  // ----------------------------------------------------- TX line monitor
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && tx_out === 1'b0) begin
        logic [9:0] fr;
        logic [7:0] b;
        int         p;
        bit         aborted;
        p = m_div + 1;
        aborted = 1'b0;
        check(tx_exp.size() != 0, "tx_frame_expected", 32'(tx_exp.size()), 1);
        b = (tx_exp.size() != 0) ? tx_exp.pop_front() : 8'h00;
        fr = {1'b1, b, 1'b0};
        for (int k = 0; k < 10 && !aborted; k++) begin
          bit ok;
          ok = 1'b1;
          for (int j = 0; j < p; j++) begin
            if (k != 0 || j != 0) @(negedge clk);
            if (reset !== 1'b0) begin
              aborted = 1'b1;
              break;
            end
            if (tx_out !== fr[k]) ok = 1'b0;
          end
          if (!aborted) check(ok, $sformatf("tx_byte%02h_bit%0d", b, k), 32'(tx_out), 32'(fr[k]));
        end
      end
    end
  end

  // ------------------------------------------------------------ watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------------------ stimulus
  initial begin
    logic [31:0] d;
    int          lat, n;

    reset = 1'b1; stb = 1'b0; we = 1'b0; addr = '0; dtw = '0; rx_in = 1'b1;
    m_div = 867; m_ctrl = '0; m_rovr = 0; m_ferr = 0; m_tovf = 0;
    repeat (3) @(negedge clk);
    check(tx_out === 1'b1, "rst_tx_out", 32'(tx_out), 1);
    check(tx_oe  === 1'b0, "rst_tx_oe",  32'(tx_oe),  0);
    check(intrq  === 1'b0, "rst_intrq",  32'(intrq),  0);
    check(ack    === 1'b0, "rst_ack",    32'(ack),    0);
    check(dtr    === '0,   "rst_dtr",    dtr,         0);
    reset = 1'b0;
    @(negedge clk);
    rd_status("rst_status");
    rd(2'd3, 32'd867, "rst_div");
    rd(2'd2, 32'd0, "rst_ctrl");

    // DIV readback with clamping of small values
    for (int i = 0; i < 6; i++) begin
      d = (i < 3) ? 32'(i) : $urandom;
      write_div(d);
      rd(2'd3, 32'(m_div), "div_readback");
    end

    // CTRL readback, tx_oe and idle interrupt
    for (int i = 0; i < 4; i++) begin
      write_ctrl($urandom);
      check(tx_oe === m_ctrl[0], "ctrl_tx_oe", 32'(tx_oe), 32'(m_ctrl[0]));
      rd(2'd2, 32'(m_ctrl), "ctrl_readback");
      check(intrq === exp_intrq(), "ctrl_intrq", 32'(intrq), 32'(exp_intrq()));
    end
    write_ctrl(0);

    // Directed 0xA5 frame at DIV=15, start-bit latency
    write_div(15);
    write_ctrl(32'h1);
    write_data(8'hA5);
    lat = 0;
    while (tx_out !== 1'b0 && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    check(lat <= 2, "tx_start_latency", 32'(lat), 2);
    wait_tx_drain(1);
    rd_status("tx_idle_status");
    write_ctrl(32'h9);
    check(intrq === 1'b1, "intrq_tx_empty", 32'(intrq), 1);

    // TX FIFO fill with transmitter disabled, then drain at a random DIV
    for (int it = 0; it < 2; it++) begin
      write_ctrl(0);
      n = (it == 0) ? 5 : int'($urandom_range(1, 6));
      for (int j = 0; j < n; j++) write_data(8'($urandom));
      rd_status("tx_fill_status");
      clear_flags(32'h40);
      rd_status("tx_ovf_cleared");
      write_div($urandom_range(3, 12));
      write_ctrl(32'h1);
      wait_tx_drain(n);
      rd_status("tx_drained_status");
    end

    // RX at DIV=15 with the RX interrupt
    write_ctrl(0);
    write_div(15);
    write_ctrl(32'h6);
    for (int i = 0; i < 4; i++) begin
      send_frame((i == 0) ? 8'h3C : 8'($urandom), 1'b1);
      check(intrq === exp_intrq(), "rx_intrq_set", 32'(intrq), 32'(exp_intrq()));
      rd_status("rx_status");
      rd_pop("rx_data");
      check(intrq === exp_intrq(), "rx_intrq_clr", 32'(intrq), 32'(exp_intrq()));
      rd_status("rx_status_empty");
    end

    // Framing error, then a short low glitch
    send_frame(8'h55, 1'b0);
    rd_status("frame_err_status");
    clear_flags(32'h20);
    rd_status("frame_err_cleared");
    @(negedge clk);
    rx_in = 1'b0;
    repeat (8) @(negedge clk);
    rx_in = 1'b1;
    repeat (40) @(negedge clk);
    rd_status("glitch_status");

    // RX overrun
    write_ctrl(32'h2);
    for (int i = 0; i < 5; i++) send_frame(8'($urandom), 1'b1);
    rd_status("overrun_status");
    for (int i = 0; i < 5; i++) rd_pop("overrun_data");
    clear_flags(32'h10);
    rd_status("overrun_cleared");

    // Reset in the middle of a TX frame
    write_ctrl(32'h1);
    write_data(8'($urandom));
    repeat (60) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check(tx_out === 1'b1, "midrst_tx_out", 32'(tx_out), 1);
    check(tx_oe  === 1'b0, "midrst_tx_oe",  32'(tx_oe),  0);
    tx_q.delete(); rx_q.delete(); tx_exp.delete();
    m_div = 867; m_ctrl = '0; m_rovr = 0; m_ferr = 0; m_tovf = 0;
    reset = 1'b0;
    @(negedge clk);
    rd_status("midrst_status");
    rd(2'd3, 32'd867, "midrst_div");
    rd(2'd2, 32'd0, "midrst_ctrl");

    repeat (5) @(negedge clk);
    check(sb_q.size() == 0, "scoreboard_drained", 32'(sb_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
